// File: rtl/i2c_slave_regfile.sv
// Oversampled I2C slave with a 2^PTR_W byte register window.
// First written byte sets the register pointer, later bytes become write strobes;
// reads return host bytes from the pointer, which auto-increments and wraps.
module i2c_slave_regfile #(
  parameter logic [6:0] I2C_ADDR    = 7'h27,
  parameter int         PTR_W       = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);
  // Fewer than two synchroniser stages is never safe, so clamp.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, PTR, ACK_P, WDATA, ACK_D, RDATA, MACK
  } state_t;

  logic [SS-1:0]    scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic             scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic             scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             busy_q, busy_d;
  logic             sda_oe_q, sda_oe_d;
  logic             wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       byte_in;

  // Synchroniser shift and one extra stage for edge detection.
  always_comb begin
    scl_sync_d = {scl_sync_q[SS-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SS-2:0], sda_i};
    scl_prev_d = scl_sync_q[SS-1];
    sda_prev_d = sda_sync_q[SS-1];
  end

  // Synchroniser registers idle high like a released bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_s     = scl_sync_q[SS-1];
  assign sda_s     = sda_sync_q[SS-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_in   = {shift_q[6:0], sda_s};

  // Protocol FSM: next state, shifter, pointer and output strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    // A write strobe bumps the pointer one clock after it is issued.
    if (wr_valid_q) ptr_d = ptr_q + PTR_W'(1);

    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (byte_in[7:1] == I2C_ADDR) begin
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                  state_d = ACK_A;
                end else begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
                end
              end else if (state_q == PTR) begin
                ptr_d   = byte_in[PTR_W-1:0];
                state_d = ACK_P;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = byte_in;
                state_d    = ACK_D;
              end
            end
          end
        end
        ACK_A, ACK_P, ACK_D: begin
          // First fall pulls SDA low, second fall ends the ACK slot.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              if (state_q == ACK_A && rw_q) begin
                shift_d  = rd_data;
                sda_oe_d = ~rd_data[7];
                state_d  = RDATA;
              end else if (state_q == ACK_A) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + PTR_W'(1);
              cnt_d    = 3'd0;
              state_d  = MACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
              cnt_d    = cnt_q + 3'd1;
            end
          end
        end
        MACK: begin
          // cnt_q==1 marks that the master ACKed on this SCL high.
          if (scl_rise) begin
            if (sda_s) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              cnt_d = 3'd1;
            end
          end else if (scl_fall && cnt_q == 3'd1) begin
            shift_d  = rd_data;
            sda_oe_d = ~rd_data[7];
            cnt_d    = 3'd0;
            state_d  = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Protocol state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'd0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = ptr_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench: bit-banged I2C master, host register bank and a
// transaction-level model (expected memory, pointer, write list).
module tb_i2c_slave_regfile;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, wr_valid, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic       sda_bus;
  logic       rd_mode = 1'b0;

  logic [7:0] host_mem [16];
  logic       mem_init_done = 1'b0;
  logic [11:0] got_q[$];
  int          got_idx = 0;
  int          oe_cnt = 0;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_mem [16];
  int          exp_ptr = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  wdat [8];

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;
  assign rd_data = rd_mode ? (8'hC0 | {4'h0, rd_addr}) : host_mem[rd_addr];

  i2c_slave_regfile #(.I2C_ADDR(7'h27), .PTR_W(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(8'h31 + i * 8'd29);
  endfunction

  // Host register bank and capture of every write strobe.
  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 16; i++) host_mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (wr_valid) begin
      host_mem[wr_addr] <= wr_data;
      got_q.push_back({wr_addr, wr_data});
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  // Compare the strobes seen since the last call with the model's list.
  task automatic check_writes(input string tag);
    int n;
    n = got_q.size() - got_idx;
    check(tag, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check(tag, got_q[got_idx + i], exp_q[i]);
    got_idx = got_q.size();
    exp_q.delete();
  endtask

  function automatic logic [7:0] exp_rd(input int p);
    return rd_mode ? (8'hC0 | 8'(p)) : exp_mem[p];
  endfunction

  // Full write transfer: pointer byte then n data bytes from wdat.
  task automatic xfer_write(input logic [7:0] p, input int n);
    logic ack;
    i2c_start();
    send_byte(8'h4E, ack); check("wr addr ack", ack, 1);
    send_byte(p, ack);     check("wr ptr ack", ack, 1);
    exp_ptr = p % 16;
    for (int i = 0; i < n; i++) begin
      send_byte(wdat[i], ack); check("wr data ack", ack, 1);
      exp_q.push_back({4'(exp_ptr), wdat[i]});
      exp_mem[exp_ptr] = wdat[i];
      exp_ptr = (exp_ptr + 1) % 16;
    end
    check("busy before stop", busy, 1);
    i2c_stop();
    tick(4);
    check("busy after stop", busy, 0);
    check("ptr after write", rd_addr, exp_ptr);
    check_writes("write list");
  endtask

  // Read transfer from the current pointer, NACKing the last byte.
  task automatic xfer_read(input int n);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'h4F, ack); check("rd addr ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(d, (i == n - 1));
      check("read byte", d, exp_rd(exp_ptr));
      exp_ptr = (exp_ptr + 1) % 16;
    end
    tick(4);
    check("sda released after nack", sda_oe, 0);
    check("busy after nack", busy, 0);
    i2c_stop();
    check("ptr after read", rd_addr, exp_ptr);
  endtask

  initial begin
    logic       ack, b;
    logic [7:0] d;
    int         kind, n;
    logic [6:0] a;

    for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);

    // Reset state
    tick(3);
    check("reset sda_oe", sda_oe, 0);
    check("reset wr_valid", wr_valid, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset wr_data", wr_data, 0);
    check("reset busy", busy, 0);
    check("reset ptr", rd_addr, 0);
    rst_n = 1'b1;
    tick(5);

    // Pointer 3, two data bytes
    wdat[0] = 8'hA5; wdat[1] = 8'h5A;
    xfer_write(8'h03, 2);

    // Pointer write then repeated-START read with address-derived data
    rd_mode = 1'b1;
    i2c_start();
    send_byte(8'h4E, ack); check("t2 addr ack", ack, 1);
    send_byte(8'h02, ack); check("t2 ptr ack", ack, 1);
    exp_ptr = 2;
    xfer_read(2);
    rd_mode = 1'b0;
    check("t2 final ptr", rd_addr, 4);

    // Foreign address is ignored
    begin
      int oe0;
      oe0 = oe_cnt;
      i2c_start();
      send_byte(8'h50, ack); check("foreign addr nack", ack, 0);
      send_byte(8'h11, ack); check("foreign data nack", ack, 0);
      check("foreign busy", busy, 0);
      i2c_stop();
      tick(2);
      check("foreign sda_oe cycles", oe_cnt - oe0, 0);
      check_writes("foreign writes");
    end

    // Pointer wrap 15 -> 0
    wdat[0] = 8'h01; wdat[1] = 8'h02;
    xfer_write(8'h0F, 2);

    // Reset in the middle of read bit 4 (0xC0 -> bit4 = 0, driven low)
    rd_mode = 1'b1;
    i2c_start();
    send_byte(8'h4E, ack); check("t5 addr ack", ack, 1);
    send_byte(8'h00, ack); check("t5 ptr ack", ack, 1);
    i2c_start();
    send_byte(8'h4F, ack); check("t5 rd ack", ack, 1);
    for (int i = 0; i < 3; i++) recv_bit(b);
    scl_m = 1'b1;
    tick(2);
    check("t5 bit4 driven", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("t5 sda_oe in reset", sda_oe, 0);
    check("t5 busy in reset", busy, 0);
    tick(3);
    rst_n = 1'b1;
    rd_mode = 1'b0;
    sda_m = 1'b1;
    tick(Q);
    exp_ptr = 0;
    check("t5 ptr after reset", rd_addr, 0);
    i2c_start();
    send_byte(8'h4E, ack); check("t5 post addr ack", ack, 1);
    send_byte(8'h00, ack); check("t5 post ptr ack", ack, 1);
    i2c_stop();
    tick(4);
    check_writes("t5 writes");

    // STOP after 5 bits of a data byte
    i2c_start();
    send_byte(8'h4E, ack); check("t6 addr ack", ack, 1);
    send_byte(8'h07, ack); check("t6 ptr ack", ack, 1);
    send_byte(8'h11, ack); check("t6 data ack", ack, 1);
    exp_q.push_back({4'd7, 8'h11});
    exp_mem[7] = 8'h11;
    exp_ptr = 8;
    d = 8'h9C;
    for (int i = 7; i > 2; i--) send_bit(d[i]);
    i2c_stop();
    tick(4);
    check("t6 busy", busy, 0);
    check("t6 ptr kept", rd_addr, 8);
    check_writes("t6 writes");
    xfer_read(1);

    // Randomised transfers against the model
    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
        xfer_write(8'($urandom), n);
      end else if (kind == 1) begin
        xfer_read($urandom_range(1, 3));
      end else begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h27) a = 7'h28;
        i2c_start();
        send_byte({a, 1'($urandom)}, ack);
        check("rand foreign nack", ack, 0);
        check("rand foreign busy", busy, 0);
        i2c_stop();
        check("rand foreign ptr", rd_addr, exp_ptr);
      end
    end
    tick(10);
    check_writes("final writes");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Synchronous, oversampled I2C slave with a parametrised 7-bit address and a byte-wide register window of 2^PTR_W locations.
- Decodes START, repeated START and STOP, and ACKs only its own address.
- Write transfer: the first data byte loads the register pointer; later bytes are emitted as write strobes to the host logic.
- Read transfer: returns host-supplied bytes from the current pointer.
- The pointer auto-increments after every data byte and wraps at the top of the window.
- Sits between the board I2C pins (open-drain pad) and a local register bank.

Parameters:
- I2C_ADDR, 7'h27, slave address compared against the first 7 bits after START or repeated START.
- PTR_W, 4, register pointer width; window = 2^PTR_W bytes.
- SYNC_STAGES, 2, synchroniser flops on scl_i and sda_i (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 10x the SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl_i  input  1  SCL pin level (asynchronous).
- sda_i  input  1  SDA pin level (asynchronous).
- sda_oe  output  1  1 = pull SDA low, 0 = release (pad is open-drain).
- wr_valid  output  1  one-clk strobe: a data byte was received.
- wr_addr  output  PTR_W  register address for wr_valid.
- wr_data  output  8  received byte for wr_valid.
- rd_addr  output  PTR_W  current pointer; host returns the matching byte on rd_data.
- rd_data  input  8  read byte; combinational from rd_addr, must be stable within 1 clk.
- busy  output  1  high from an address match until STOP, NACK or mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0.
  - Pointer=0, bit counter=0, state=IDLE.
  - Synchroniser flops reset to 1.
  - Takes effect immediately, including mid-byte; SDA is released at once.
- Input sampling: scl/sda pass through SYNC_STAGES flops, then one extra flop for edge detection. All decisions use the synchronised values.
- START / repeated START: sda falls while scl high, in any state.
  - Actions: state=ADDR, bit counter=0, sda_oe=0.
  - The pointer is kept, so write-pointer followed by repeated-START read works.
- STOP: sda rises while scl high, in any state.
  - Actions: state=IDLE, sda_oe=0, busy=0.
- Data capture and drive timing:
  - Data bits are sampled on the scl rising edge, MSB first.
  - sda_oe changes only on the clk after a detected scl falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th rise, compare bits[7:1] to I2C_ADDR and latch bit0 as rw. On match, set busy=1 and go to ACK_A. On mismatch, go to IDLE with no drive.
  - ACK_A: on the scl fall, sda_oe=1 for one SCL period. On the next scl fall, sda_oe=0. If rw=0, go to PTR. If rw=1, load the shift register from rd_data, go to RDATA and drive bit7 in the same clk.
  - PTR: shift 8 bits; the pointer takes the low PTR_W bits of the byte. Then go to ACK_P (ACK as in ACK_A), then WDATA.
  - WDATA: shift 8 bits. On the 8th rise: wr_valid=1 for 1 clk, with wr_addr=pointer and wr_data=byte. The pointer increments in the next clk, modulo 2^PTR_W. Then go to ACK_D (ACK as in ACK_A), then WDATA.
  - RDATA: on each scl fall, sda_oe = ~current bit (a 0 bit pulls low). After the 8th bit's fall, release SDA, increment the pointer and go to MACK.
  - MACK: sample SDA on the scl rise.
    - SDA=0 (master ACK): at the next fall, load rd_data at the new pointer and return to RDATA.
    - SDA=1 (master NACK): go to IDLE with SDA released and busy=0.
- Boundaries:
  - No clock stretching.
  - A repeated START during any ACK phase releases SDA first.
  - START and STOP detected in the same clk is impossible (single sda edge).
  - A STOP before the pointer byte completes leaves the pointer unchanged.
  - A partial byte is discarded on STOP or START, with no wr_valid.
  - wr_valid is never asserted for address or pointer bytes.
  - Pointer wrap: 2^PTR_W-1 increments to 0.

Test Plan:
- START, 0x4E (0x27,W), 0x03, 0xA5, 0x5A, STOP -> ACK on all four 9th clocks; wr_valid twice: (3,0xA5) then (4,0x5A); busy falls at STOP.
- START, 0x4E, 0x02, Sr, 0x4F, host rd_data=8'hC0|rd_addr -> SDA carries 0xC2 then 0xC3; master ACKs the first byte and NACKs the second; final pointer=4; sda_oe=0 after NACK.
- START, 0x50 (0x28,W), 0x11 -> sda_oe stays 0 throughout, no wr_valid, busy stays 0.
- START, 0x4E, 0x0F, 0x01, 0x02, STOP -> wr_valid at addr 15 then addr 0 (wrap).
- Pull rst_n low for 3 clks in the middle of RDATA bit 4 -> sda_oe=0 in the same cycle; a following START, 0x4E, 0x00 transfer is ACKed normally.
- STOP after 5 bits of a WDATA byte -> no wr_valid, state IDLE; the next write resumes at the previous pointer.
